mouse_tracker: RTL and testbench

Parametrised PS/2 mouse front end that replaces the fixed 9-bit X-only packet decoder. It sits directly above `ps2_rxtx` and owns that unit's byte handshake. It runs a full initialisation dialogue (reset, self-test check, optional IntelliMouse wheel unlock, stream enable) with ACK checking, retries and timeouts. It then decodes 3- or 4-byte packets into X/Y/Z deltas and buttons, and accumulates a saturating screen-space cursor position for the display logic.

---
 rtl/mouse_tracker.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_mouse_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_tracker.sv
// mouse_tracker: PS/2 mouse front end that sits directly above ps2_rxtx.
// It runs the mouse initialisation dialogue (reset, self-test, optional
// IntelliMouse wheel unlock, stream enable). Then it decodes 3- or 4-byte
// movement packets and accumulates a clamped screen-space cursor position.
//
// Handshake with ps2_rxtx (pulse based, no back-pressure):
//   wr_ps2 is a one-cycle request to send tx_data. tx_data holds its value
//   until the next request. tx_done_tick is a one-cycle pulse when the byte
//   has gone out. rx_done_tick is a one-cycle pulse marking rx_data valid in
//   that cycle. A pulse the current state is not waiting for is ignored.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   rx_data, rx_done_tick   received byte and its strobe
//   tx_done_tick            host byte sent
//   wr_ps2, tx_data         command request and command byte
//   xpos, ypos              cursor position, origin top-left
//   dx, dy, dz              deltas of the last packet (two's complement)
//   btn, ovf                {middle,right,left}, {y_ovf,x_ovf}
//   wheel_en                4-byte packets active
//   init_err                sticky: initialisation abandoned
//   m_done_tick             one-cycle pulse: new packet applied
//   dbg_state               current FSM state, for observation
module mouse_tracker #(
  parameter int PW      = 10,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int TIMEOUT = 1_000_000,
  parameter int WHEEL   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done_tick,
  input  logic          tx_done_tick,
  output logic          wr_ps2,
  output logic [7:0]    tx_data,
  output logic [PW-1:0] xpos,
  output logic [PW-1:0] ypos,
  output logic [8:0]    dx,
  output logic [8:0]    dy,
  output logic [3:0]    dz,
  output logic [2:0]    btn,
  output logic [1:0]    ovf,
  output logic          wheel_en,
  output logic          init_err,
  output logic          m_done_tick,
  output logic [4:0]    dbg_state
);

  typedef enum logic [4:0] {
    RST_TX, CMD_TX, TX_WT, ACK_WT, BAT_WT, ID_WT, DEVID_WT,
    PACK1, PACK2, PACK3, PACK4, ACC, DONE, FAIL
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0]        X_RST    = PW'(X_MAX / 2);
  localparam logic [PW-1:0]        Y_RST    = PW'(Y_MAX / 2);
  localparam logic [PW-1:0]        X_TOP    = PW'(X_MAX);
  localparam logic [PW-1:0]        Y_TOP    = PW'(Y_MAX);
  localparam logic signed [PW+1:0] X_LIM    = (PW+2)'(X_MAX);
  localparam logic signed [PW+1:0] Y_LIM    = (PW+2)'(Y_MAX);

  // Command index 0 is the reset command, 1..7 the wheel unlock and ID
  // query, 8 the stream enable.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = 8'hFF;
      4'd1:    cmd_byte = 8'hF3;
      4'd2:    cmd_byte = 8'hC8;
      4'd3:    cmd_byte = 8'hF3;
      4'd4:    cmd_byte = 8'h64;
      4'd5:    cmd_byte = 8'hF3;
      4'd6:    cmd_byte = 8'h50;
      4'd7:    cmd_byte = 8'hF2;
      default: cmd_byte = 8'hF4;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    cmd_idx_q, cmd_idx_d;
  logic [1:0]    retry_q, retry_d;
  logic          wr_ps2_q, wr_ps2_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [PW-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [8:0]    dx_q, dx_d, dy_q, dy_d;
  logic [3:0]    dz_q, dz_d;
  logic [2:0]    btn_q, btn_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          wheel_en_q, wheel_en_d;
  logic          init_err_q, init_err_d;
  // Packet-in-progress holding registers; outputs change only when the
  // final byte lands, so an abandoned packet leaves them untouched.
  logic [2:0]    pbtn_q, pbtn_d;
  logic [1:0]    povf_q, povf_d;
  logic          psx_q, psx_d, psy_q, psy_d;
  logic [7:0]    pxb_q, pxb_d, pyb_q, pyb_d;

  logic          tmo_hit;
  logic          init_fail;
  logic signed [PW+1:0] x_step, y_step, x_sum, y_sum;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Cursor arithmetic: position is non-negative, so zero-extend it; deltas
  // are sign-extended. An overflowed axis contributes nothing.
  always_comb begin
    x_step = ovf_q[0] ? '0 : $signed({{(PW-7){dx_q[8]}}, dx_q});
    y_step = ovf_q[1] ? '0 : $signed({{(PW-7){dy_q[8]}}, dy_q});
    x_sum  = $signed({2'b00, xpos_q}) + x_step;
    // Screen Y grows downward while PS/2 +Y is up.
    y_sum  = $signed({2'b00, ypos_q}) - y_step;
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    cmd_idx_d  = cmd_idx_q;
    retry_d    = retry_q;
    wr_ps2_d   = 1'b0;
    tx_data_d  = tx_data_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    dz_d       = dz_q;
    btn_d      = btn_q;
    ovf_d      = ovf_q;
    wheel_en_d = wheel_en_q;
    init_err_d = init_err_q;
    pbtn_d     = pbtn_q;
    povf_d     = povf_q;
    psx_d      = psx_q;
    psy_d      = psy_q;
    pxb_d      = pxb_q;
    pyb_d      = pyb_q;
    init_fail  = 1'b0;

    case (state_q)
      RST_TX: begin
        wr_ps2_d  = 1'b1;
        tx_data_d = 8'hFF;
        cmd_idx_d = 4'd0;
        state_d   = TX_WT;
      end
      CMD_TX: begin
        wr_ps2_d  = 1'b1;
        tx_data_d = cmd_byte(cmd_idx_q);
        state_d   = TX_WT;
      end
      TX_WT: begin
        if (tx_done_tick)  state_d   = ACK_WT;
        else if (tmo_hit)  init_fail = 1'b1;
        else               tmo_d     = tmo_q + 1'b1;
      end
      ACK_WT: begin
        if (rx_done_tick) begin
          if (rx_data != 8'hFA) begin
            init_fail = 1'b1;
          end else begin
            case (cmd_idx_q)
              4'd0:    state_d = BAT_WT;
              4'd7:    state_d = DEVID_WT;
              4'd8:    state_d = PACK1;
              default: begin
                cmd_idx_d = cmd_idx_q + 4'd1;
                state_d   = CMD_TX;
              end
            endcase
          end
        end else if (tmo_hit) begin
          init_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BAT_WT: begin
        if (rx_done_tick) begin
          if (rx_data == 8'hAA) state_d   = ID_WT;
          else                  init_fail = 1'b1;
        end else if (tmo_hit) begin
          init_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ID_WT: begin
        if (rx_done_tick) begin
          if (rx_data == 8'h00) begin
            cmd_idx_d = (WHEEL != 0) ? 4'd1 : 4'd8;
            state_d   = CMD_TX;
          end else begin
            init_fail = 1'b1;
          end
        end else if (tmo_hit) begin
          init_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DEVID_WT: begin
        // Any ID is acceptable; only 0x03 means the wheel unlock took.
        if (rx_done_tick) begin
          wheel_en_d = (rx_data == 8'h03);
          cmd_idx_d  = 4'd8;
          state_d    = CMD_TX;
        end else if (tmo_hit) begin
          init_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PACK1: begin
        // Bit 3 of the header byte is always set; anything else is a
        // stray byte and is dropped to resynchronise.
        if (rx_done_tick && rx_data[3]) begin
          pbtn_d  = rx_data[2:0];
          psx_d   = rx_data[4];
          psy_d   = rx_data[5];
          povf_d  = rx_data[7:6];
          state_d = PACK2;
        end
      end
      PACK2: begin
        if (rx_done_tick) begin
          pxb_d   = rx_data;
          state_d = PACK3;
        end else if (tmo_hit) begin
          state_d = PACK1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PACK3: begin
        if (rx_done_tick) begin
          if (wheel_en_q) begin
            pyb_d   = rx_data;
            state_d = PACK4;
          end else begin
            dx_d    = {psx_q, pxb_q};
            dy_d    = {psy_q, rx_data};
            dz_d    = 4'd0;
            btn_d   = pbtn_q;
            ovf_d   = povf_q;
            state_d = ACC;
          end
        end else if (tmo_hit) begin
          state_d = PACK1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PACK4: begin
        if (rx_done_tick) begin
          dx_d    = {psx_q, pxb_q};
          dy_d    = {psy_q, pyb_q};
          dz_d    = rx_data[3:0];
          btn_d   = pbtn_q;
          ovf_d   = povf_q;
          state_d = ACC;
        end else if (tmo_hit) begin
          state_d = PACK1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ACC: begin
        if (x_sum < 0)          xpos_d = '0;
        else if (x_sum > X_LIM) xpos_d = X_TOP;
        else                    xpos_d = x_sum[PW-1:0];
        if (y_sum < 0)          ypos_d = '0;
        else if (y_sum > Y_LIM) ypos_d = Y_TOP;
        else                    ypos_d = y_sum[PW-1:0];
        state_d = DONE;
      end
      DONE:    state_d = PACK1;
      FAIL:    state_d = FAIL;
      default: state_d = RST_TX;
    endcase

    // Third failed attempt gives up for good; earlier ones restart the
    // dialogue from the reset command.
    if (init_fail) begin
      if (retry_q == 2'd2) begin
        init_err_d = 1'b1;
        state_d    = FAIL;
      end else begin
        retry_d    = retry_q + 2'd1;
        wheel_en_d = 1'b0;
        state_d    = RST_TX;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_TX;
      tmo_q      <= '0;
      cmd_idx_q  <= 4'd0;
      retry_q    <= 2'd0;
      wr_ps2_q   <= 1'b0;
      tx_data_q  <= 8'hFF;
      xpos_q     <= X_RST;
      ypos_q     <= Y_RST;
      dx_q       <= 9'd0;
      dy_q       <= 9'd0;
      dz_q       <= 4'd0;
      btn_q      <= 3'd0;
      ovf_q      <= 2'd0;
      wheel_en_q <= 1'b0;
      init_err_q <= 1'b0;
      pbtn_q     <= 3'd0;
      povf_q     <= 2'd0;
      psx_q      <= 1'b0;
      psy_q      <= 1'b0;
      pxb_q      <= 8'd0;
      pyb_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      cmd_idx_q  <= cmd_idx_d;
      retry_q    <= retry_d;
      wr_ps2_q   <= wr_ps2_d;
      tx_data_q  <= tx_data_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      dz_q       <= dz_d;
      btn_q      <= btn_d;
      ovf_q      <= ovf_d;
      wheel_en_q <= wheel_en_d;
      init_err_q <= init_err_d;
      pbtn_q     <= pbtn_d;
      povf_q     <= povf_d;
      psx_q      <= psx_d;
      psy_q      <= psy_d;
      pxb_q      <= pxb_d;
      pyb_q      <= pyb_d;
    end
  end

  assign wr_ps2      = wr_ps2_q;
  assign tx_data     = tx_data_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign dx          = dx_q;
  assign dy          = dy_q;
  assign dz          = dz_q;
  assign btn         = btn_q;
  assign ovf         = ovf_q;
  assign wheel_en    = wheel_en_q;
  assign init_err    = init_err_q;
  assign m_done_tick = (state_q == DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Bench for mouse_tracker: a scripted mouse answers the init dialogue, then
// a table of packets is applied with hand-computed cursor/delta results,
// followed by sequences for resync, inter-byte timeout, mid-packet reset,
// NAK retries and a silent mouse.
module tb_mouse_tracker;
  localparam int PW  = 10;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done_tick = 1'b0;
  logic          tx_done_tick = 1'b0;
  logic          wr_ps2;
  logic [7:0]    tx_data;
  logic [PW-1:0] xpos, ypos;
  logic [8:0]    dx, dy;
  logic [3:0]    dz;
  logic [2:0]    btn;
  logic [1:0]    ovf;
  logic          wheel_en, init_err, m_done_tick;
  logic [4:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  mouse_tracker #(.PW(PW), .X_MAX(639), .Y_MAX(479), .TIMEOUT(TMO), .WHEEL(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .tx_data(tx_data),
    .xpos(xpos), .ypos(ypos), .dx(dx), .dy(dy), .dz(dz), .btn(btn), .ovf(ovf),
    .wheel_en(wheel_en), .init_err(init_err), .m_done_tick(m_done_tick),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_done_tick) done_cnt++;
    if (wr_ps2) wr_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0]   pkt;   // byte 0 in [31:24]
    int            nb;
    logic [PW-1:0] x, y;
    logic [8:0]    dx, dy;
    logic [3:0]    dz;
    logic [2:0]    btn;
    logic [1:0]    ovf;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] pkt, input int nb,
                              input int x, input int y,
                              input logic [8:0] vdx, input logic [8:0] vdy,
                              input logic [3:0] vdz, input logic [2:0] vbtn,
                              input logic [1:0] vovf);
    vec_t v;
    v.pkt = pkt; v.nb = nb; v.x = PW'(x); v.y = PW'(y);
    v.dx = vdx; v.dy = vdy; v.dz = vdz; v.btn = vbtn; v.ovf = vovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_wr(input logic [7:0] exp, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr_ps2) begin lat = i; break; end
    end
    check("wr_seen", 32'(lat >= 0), 32'd1);
    if (lat >= 0) check("tx_data", 32'(tx_data), 32'(exp));
  endtask

  task automatic cmd_step(input logic [7:0] cmd, input logic [7:0] reply, output int lat);
    wait_wr(cmd, lat);
    repeat (2) @(posedge clk);
    #1 tx_done_tick = 1'b1;
    @(posedge clk); #1 tx_done_tick = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(reply);
  endtask

  task automatic do_init(input logic [7:0] id);
    logic [7:0] seq [9];
    int lat;
    seq = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
    cmd_step(seq[0], 8'hFA, lat);
    check("first_wr_latency", 32'(lat), 32'd0);
    send_byte(8'hAA);
    repeat (2) @(posedge clk);
    send_byte(8'h00);
    for (int i = 1; i < 9; i++) begin
      cmd_step(seq[i], 8'hFA, lat);
      if (i == 7) begin
        repeat (2) @(posedge clk);
        send_byte(id);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  // Applies a packet and checks the 2-cycle m_done_tick latency and results.
  task automatic apply_pkt(input vec_t v, input int idx);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.pkt[31-8*i -: 8]);
      if (i < v.nb - 1) repeat (3) @(posedge clk);
    end
    @(negedge clk);
    check($sformatf("v%0d_done_early", idx), 32'(m_done_tick), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_done", idx), 32'(m_done_tick), 32'd1);
    check($sformatf("v%0d_xpos", idx), 32'(xpos), 32'(v.x));
    check($sformatf("v%0d_ypos", idx), 32'(ypos), 32'(v.y));
    check($sformatf("v%0d_dx", idx), 32'(dx), 32'(v.dx));
    check($sformatf("v%0d_dy", idx), 32'(dy), 32'(v.dy));
    check($sformatf("v%0d_dz", idx), 32'(dz), 32'(v.dz));
    check($sformatf("v%0d_btn", idx), 32'(btn), 32'(v.btn));
    check($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
    @(negedge clk);
    check($sformatf("v%0d_done_once", idx), 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_xpos"}, 32'(xpos), 32'd319);
    check({tag, "_ypos"}, 32'(ypos), 32'd239);
    check({tag, "_dx"}, 32'(dx), 32'd0);
    check({tag, "_dy"}, 32'(dy), 32'd0);
    check({tag, "_dz"}, 32'(dz), 32'd0);
    check({tag, "_btn"}, 32'(btn), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_wheel_en"}, 32'(wheel_en), 32'd0);
    check({tag, "_init_err"}, 32'(init_err), 32'd0);
    check({tag, "_m_done"}, 32'(m_done_tick), 32'd0);
    check({tag, "_wr_ps2"}, 32'(wr_ps2), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'hFF);
  endtask

  vec_t vecs [15];

  initial begin
    int lat, d0, w0, waited;

    // Wheel-mode packets; cursor starts at (319,239).
    vecs[0]  = mk(32'h2914F60F, 4, 339, 249, 9'h014, 9'h1F6, 4'hF, 3'b001, 2'b00);
    vecs[1]  = mk(32'h087F0000, 4, 466, 249, 9'h07F, 9'h000, 4'h0, 3'b000, 2'b00);
    vecs[2]  = mk(32'h087F0000, 4, 593, 249, 9'h07F, 9'h000, 4'h0, 3'b000, 2'b00);
    vecs[3]  = mk(32'h087F0000, 4, 639, 249, 9'h07F, 9'h000, 4'h0, 3'b000, 2'b00);
    vecs[4]  = mk(32'h18800000, 4, 511, 249, 9'h180, 9'h000, 4'h0, 3'b000, 2'b00);
    vecs[5]  = mk(32'h487F0000, 4, 511, 249, 9'h07F, 9'h000, 4'h0, 3'b000, 2'b01);
    vecs[6]  = mk(32'h08007F01, 4, 511, 122, 9'h000, 9'h07F, 4'h1, 3'b000, 2'b00);
    vecs[7]  = mk(32'h08007F00, 4, 511,   0, 9'h000, 9'h07F, 4'h0, 3'b000, 2'b00);
    vecs[8]  = mk(32'h2C00800E, 4, 511, 128, 9'h000, 9'h180, 4'hE, 3'b100, 2'b00);
    vecs[9]  = mk(32'h3AF0F000, 4, 495, 144, 9'h1F0, 9'h1F0, 4'h0, 3'b010, 2'b00);
    vecs[10] = mk(32'h88055000, 4, 500, 144, 9'h005, 9'h050, 4'h0, 3'b000, 2'b10);
    vecs[11] = mk(32'h28000100, 4, 500, 399, 9'h000, 9'h101, 4'h0, 3'b000, 2'b00);
    vecs[12] = mk(32'h28000100, 4, 500, 479, 9'h000, 9'h101, 4'h0, 3'b000, 2'b00);
    vecs[13] = mk(32'h18010000, 4, 245, 479, 9'h101, 9'h000, 4'h0, 3'b000, 2'b00);
    vecs[14] = mk(32'h18010000, 4,   0, 479, 9'h101, 9'h000, 4'h0, 3'b000, 2'b00);

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk) reset = 1'b1;

    // Full wheel init
    w0 = wr_cnt;
    do_init(8'h03);
    check("wheel_en_set", 32'(wheel_en), 32'd1);
    check("init_wr_count", 32'(wr_cnt - w0), 32'd9);

    foreach (vecs[i]) apply_pkt(vecs[i], i);

    // Reset pulled while the device is between the X and Y bytes.
    send_byte(8'h08);
    repeat (3) @(posedge clk);
    send_byte(8'h05);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk) reset = 1'b1;

    // Re-init; the mouse reports a plain ID, so 3-byte packets follow.
    do_init(8'h00);
    check("wheel_en_clear", 32'(wheel_en), 32'd0);

    // Stray byte with bit3=0 is dropped before a valid packet.
    d0 = done_cnt;
    send_byte(8'h00);
    repeat (3) @(posedge clk);
    apply_pkt(mk(32'h08010100, 3, 320, 238, 9'h001, 9'h001, 4'h0, 3'b000, 2'b00), 100);
    check("resync_single_done", 32'(done_cnt - d0), 32'd1);

    // Inter-byte gap beyond the timeout abandons the packet silently.
    d0 = done_cnt;
    send_byte(8'h08);
    repeat (TMO + 20) @(posedge clk);
    check("gap_no_done", 32'(done_cnt - d0), 32'd0);
    check("gap_xpos_kept", 32'(xpos), 32'd320);
    check("gap_dx_kept", 32'(dx), 32'h001);
    apply_pkt(mk(32'h09020200, 3, 322, 236, 9'h002, 9'h002, 4'h0, 3'b001, 2'b00), 101);

    // Mouse NAKs the reset command three times.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int r = 0; r < 3; r++) cmd_step(8'hFF, 8'hFE, lat);
    repeat (3) @(negedge clk);
    check("nak_init_err", 32'(init_err), 32'd1);
    w0 = wr_cnt;
    repeat (200) @(negedge clk);
    check("nak_no_more_wr", 32'(wr_cnt - w0), 32'd0);

    // Silent mouse: three timeouts on the reset command.
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("silent_err_cleared", 32'(init_err), 32'd0);
    reset = 1'b1;
    for (int r = 0; r < 3; r++) wait_wr(8'hFF, lat);
    waited = -1;
    for (int i = 0; i < 4 * TMO; i++) begin
      @(negedge clk);
      if (init_err) begin waited = i; break; end
    end
    check("silent_init_err", 32'(waited >= 0), 32'd1);
    w0 = wr_cnt;
    repeat (4 * TMO) @(negedge clk);
    check("silent_no_more_wr", 32'(wr_cnt - w0), 32'd0);
    check("silent_init_err_sticky", 32'(init_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
